blk_transpose_8x8: RTL and testbench



---
 rtl/jpeg_blk_pkg.sv | 15 +
 rtl/ram_8bx8.sv | 22 ++
 rtl/blk_transpose_8x8.sv | 96 +++++++++
 tb/tb_blk_transpose_8x8.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_blk_pkg.sv
// rtl/jpeg_blk_pkg.sv - shared types and constants for the 8x8 pixel block datapath
package jpeg_blk_pkg;

  localparam int BLK_N = 8;
  localparam int PIX_W = 8;

  typedef logic [PIX_W-1:0] pix_t;
  typedef pix_t [0:BLK_N-1] col_t;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/ram_8bx8.sv
// rtl/ram_8bx8.sv - 8 x 8-bit single-port bank, synchronous write, registered read
module ram_8bx8
  import jpeg_blk_pkg::pix_t;
(
  input  logic       clk,
  input  logic       we,
  input  logic [2:0] addr,
  input  pix_t       din,
  output pix_t       dout
);

  pix_t mem [0:7];

  // Write when enabled; the read port re-reads the addressed word every cycle
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/blk_transpose_8x8.sv
// rtl/blk_transpose_8x8.sv - row-major pixel fill, column-vector drain transpose buffer
module blk_transpose_8x8
  import jpeg_blk_pkg::state_t;
  import jpeg_blk_pkg::FILL;
  import jpeg_blk_pkg::DRAIN;
  import jpeg_blk_pkg::pix_t;
#(
  parameter int PIX_W = 8,
  parameter int BLK_N = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PIX_W-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BLK_N*PIX_W-1:0] out_data,
  output logic [2:0]             out_col,
  output logic                   out_last
);

  state_t     state;
  logic [5:0] wr_cnt;
  logic [2:0] rd_col;
  logic [2:0] addr;
  logic       fire;
  pix_t       bank_dout [BLK_N];

  assign fire    = out_valid & out_ready;
  assign out_col = rd_col;

  // Banks share one address. While draining, an accepted column advances the
  // address in the same cycle so the next column lands on the following edge;
  // a stalled column keeps re-reading the same address and so stays stable.
  always_comb begin
    addr = wr_cnt[2:0];
    if (state == DRAIN) begin
      addr = rd_col + {2'b00, fire};
    end
  end

  // One bank per row; pixel (r,c) goes to bank r at address c
  for (genvar r = 0; r < BLK_N; r++) begin : g_bank
    ram_8bx8 u_bank (
      .clk  (clk),
      .we   ((state == FILL) && in_valid && (wr_cnt[5:3] == 3'(r))),
      .addr (addr),
      .din  (in_data),
      .dout (bank_dout[r])
    );
    assign out_data[PIX_W*r +: PIX_W] = bank_dout[r];
  end

  // Fill/drain control with registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      wr_cnt    <= 6'd0;
      rd_col    <= 3'd0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        FILL: begin
          if (in_valid && in_ready) begin
            wr_cnt <= wr_cnt + 6'd1;
            if (wr_cnt == 6'd63) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (!out_valid) begin
            // Read bubble: column 0 address was presented this cycle
            out_valid <= 1'b1;
          end else if (out_ready) begin
            rd_col <= rd_col + 3'd1;
            if (out_last) begin
              state     <= FILL;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
            end else begin
              out_last <= (rd_col == 3'd6);
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_blk_transpose_8x8.sv
// tb/tb_blk_transpose_8x8.sv - scoreboard bench for the 8x8 block transpose buffer
module tb_blk_transpose_8x8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [2:0]  out_col;
  logic        out_last;

  int tests = 0;
  int fails = 0;

  logic [63:0] exp_q [$];
  logic [7:0]  pix [64];

  blk_transpose_8x8 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_col   (out_col),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // Drive n pixels (base+k) in raster order; mode 1 uses the 1,0,0,1 valid pattern.
  // A complete block pushes its eight expected columns to the scoreboard.
  task automatic fill_block(input int base, input int mode, input int n);
    int k = 0;
    int i = 0;
    logic [63:0] col;
    while (k < n && i < 1000) begin
      @(negedge clk);
      in_valid = (mode == 0) ? 1'b1 : ((i % 4 == 0) || (i % 4 == 3));
      in_data  = 8'(base + k);
      if (in_valid && in_ready) begin
        pix[k] = 8'(base + k);
        k++;
      end
      i++;
    end
    tests++;
    if (k !== n) begin
      fails++;
      $display("FAIL fill_accept accepted=%0d required=%0d", k, n);
    end
    if (n == 64) begin
      for (int c = 0; c < 8; c++) begin
        for (int r = 0; r < 8; r++) col[8*r +: 8] = pix[8*r + c];
        exp_q.push_back(col);
      end
    end
  endtask

  // Cycle after the 64th pixel: input closed, read bubble
  task automatic post_fill_check(input logic junk);
    @(negedge clk);
    in_valid  = junk;
    in_data   = 8'hEE;
    out_ready = 1'b1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL entry_in_ready got=%b required=0", in_ready);
    end
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL entry_bubble out_valid got=%b required=0", out_valid);
    end
  endtask

  // Pop/compare columns; stall 3 cycles on columns in stall_mask; abort with rst at abort_col
  task automatic drain_check(input logic [7:0] stall_mask, input logic junk, input int abort_col);
    int  c = 0;
    int  held = 0;
    int  cyc = 0;
    bit  done = 0;
    bit  aborted = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      in_valid = junk;
      in_data  = 8'($urandom);
      tests++;
      if (in_ready !== 1'b0) begin
        fails++;
        $display("FAIL drain_in_ready col=%0d got=%b required=0", c, in_ready);
      end
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_beat out_col=%0d", out_col);
          done = 1;
        end else begin
          tests++;
          if (out_data !== exp_q[0]) begin
            fails++;
            $display("FAIL col_data col=%0d got=%h required=%h", c, out_data, exp_q[0]);
          end
          tests++;
          if (out_col !== 3'(c)) begin
            fails++;
            $display("FAIL col_index got=%0d required=%0d", out_col, c);
          end
          tests++;
          if (out_last !== (c == 7)) begin
            fails++;
            $display("FAIL col_last col=%0d got=%b required=%b", c, out_last, (c == 7));
          end
          if (c == abort_col) begin
            out_ready = 1'b0;
            #2 rst = 1'b1;
            #1;
            tests++;
            if (out_valid !== 1'b0) begin
              fails++;
              $display("FAIL rst_drain_valid got=%b required=0", out_valid);
            end
            tests++;
            if (in_ready !== 1'b1) begin
              fails++;
              $display("FAIL rst_drain_ready got=%b required=1", in_ready);
            end
            exp_q.delete();
            aborted = 1;
            done = 1;
          end else if (stall_mask[c] && held < 3) begin
            out_ready = 1'b0;
            held++;
          end else begin
            out_ready = 1'b1;
            held = 0;
            void'(exp_q.pop_front());
            c++;
            if (c == 8) done = 1;
          end
        end
      end else begin
        out_ready = 1'($urandom);
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout beats=%0d required=8", c);
    end else if (aborted) begin
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
    end else begin
      @(negedge clk);
      in_valid = 1'b0;
      tests++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL post_drain_in_ready got=%b required=1", in_ready);
      end
      tests++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL post_drain_valid got=%b required=0", out_valid);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b required=0", out_valid); end
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b required=1", in_ready); end
    tests++;
    if (out_col !== 3'd0) begin fails++; $display("FAIL reset_out_col got=%0d required=0", out_col); end
    tests++;
    if (out_last !== 1'b0) begin fails++; $display("FAIL reset_out_last got=%b required=0", out_last); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    fill_block(0, 0, 64);
    post_fill_check(1'b0);
    drain_check(8'h00, 1'b0, 8);
  endtask

  task automatic test_backpressure();
    fill_block(0, 0, 64);
    post_fill_check(1'b0);
    drain_check(8'b1000_0100, 1'b0, 8);
  endtask

  task automatic test_gaps();
    fill_block(0, 1, 64);
    post_fill_check(1'b0);
    drain_check(8'h00, 1'b0, 8);
  endtask

  task automatic test_back_to_back();
    fill_block(0, 0, 64);
    post_fill_check(1'b1);
    drain_check(8'h00, 1'b1, 8);
    fill_block(64, 0, 64);
    post_fill_check(1'b1);
    drain_check(8'h00, 1'b1, 8);
  endtask

  task automatic test_rst_fill();
    fill_block(200, 0, 30);
    @(posedge clk);
    #2 rst = 1'b1;
    in_valid = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_fill_valid got=%b required=0", out_valid); end
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_fill_ready got=%b required=1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    fill_block(128, 0, 64);
    post_fill_check(1'b0);
    drain_check(8'h00, 1'b0, 8);
  endtask

  task automatic test_rst_drain();
    fill_block(32, 0, 64);
    post_fill_check(1'b0);
    drain_check(8'h00, 1'b0, 4);
    fill_block(0, 1, 64);
    post_fill_check(1'b0);
    drain_check(8'h00, 1'b0, 8);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gaps();
    test_back_to_back();
    test_rst_fill();
    test_rst_drain();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_leftover got=%0d required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
